// File: rtl/uivtc.sv
// Video timing controller: free-running raster counters produce registered
// hsync/vsync/data-enable, a frame-start pulse and active-area coordinates.
module uivtc #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        vtc_clk_i,
    input  logic        vtc_rstn_i,
    input  logic        vtc_en_i,
    output logic        vtc_vs_o,
    output logic        vtc_hs_o,
    output logic        vtc_de_o,
    output logic        vtc_fs_o,
    output logic [11:0] vtc_x_o,
    output logic [11:0] vtc_y_o
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Region bounds are 13 bits so an end bound of exactly 4096 still fits.
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
    localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
    localparam logic [12:0] H_DE_BEG   = 13'(H_SYNC + H_BP);
    localparam logic [12:0] H_DE_END   = 13'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [12:0] V_DE_BEG   = 13'(V_SYNC + V_BP);
    localparam logic [12:0] V_DE_END   = 13'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] X_OFF      = 12'(H_SYNC + H_BP);
    localparam logic [11:0] Y_OFF      = 12'(V_SYNC + V_BP);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_act;
    logic        vs_act;
    logic        h_de;
    logic        v_de;
    logic        de_now;

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign hs_act = (h_ext < H_SYNC_END);
    assign vs_act = (v_ext < V_SYNC_END);
    assign h_de   = (h_ext >= H_DE_BEG) && (h_ext < H_DE_END);
    assign v_de   = (v_ext >= V_DE_BEG) && (v_ext < V_DE_END);
    assign de_now = h_de && v_de;

    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            vtc_hs_o <= ~HS_POL;
            vtc_vs_o <= ~VS_POL;
            vtc_de_o <= 1'b0;
            vtc_fs_o <= 1'b0;
            vtc_x_o  <= '0;
            vtc_y_o  <= '0;
        end else if (!vtc_en_i) begin
            // Disable aborts at once; the next enable restarts from (0,0).
            h_cnt    <= '0;
            v_cnt    <= '0;
            vtc_hs_o <= ~HS_POL;
            vtc_vs_o <= ~VS_POL;
            vtc_de_o <= 1'b0;
            vtc_fs_o <= 1'b0;
            vtc_x_o  <= '0;
            vtc_y_o  <= '0;
        end else begin
            h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
            end
            vtc_hs_o <= hs_act ? HS_POL : ~HS_POL;
            vtc_vs_o <= vs_act ? VS_POL : ~VS_POL;
            vtc_de_o <= de_now;
            vtc_fs_o <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            vtc_x_o  <= de_now ? h_cnt - X_OFF : 12'd0;
            vtc_y_o  <= de_now ? v_cnt - Y_OFF : 12'd0;
        end
    end

endmodule

// File: doc/uivtc.md
UIVTC -- requirements
Module: uivtc

Interface
REQ-001 Parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 Parameter H_FP, default 88, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 44, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 148, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 1080, active lines per frame.
REQ-006 Parameter V_FP, default 4, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 5, vertical sync width in lines.
REQ-008 Parameter V_BP, default 36, vertical back porch in lines.
REQ-009 Parameter HS_POL, default 1, active level of vtc_hs_o.
REQ-010 Parameter VS_POL, default 1, active level of vtc_vs_o.
REQ-011 vtc_clk_i  input  1  pixel clock; all logic on rising edge.
REQ-012 vtc_rstn_i  input  1  reset; asynchronous, active-low.
REQ-013 vtc_en_i  input  1  timing enable; low forces idle.
REQ-014 vtc_vs_o  output  1  vertical sync, registered.
REQ-015 vtc_hs_o  output  1  horizontal sync, registered.
REQ-016 vtc_de_o  output  1  active-video data enable, registered.
REQ-017 vtc_fs_o  output  1  frame-start pulse, registered.
REQ-018 vtc_x_o  output  12  active pixel column, registered.
REQ-019 vtc_y_o  output  12  active line index, registered.

Function
REQ-020 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; both SHALL be at most 4096.
REQ-021 h_cnt (12 bit) SHALL count 0..H_TOTAL-1 each clock while enabled, then wrap to 0.
REQ-022 v_cnt (12 bit) SHALL increment only on the h_cnt wrap cycle, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-023 Each line is ordered as SYNC [0,H_SYNC), BP, ACTIVE [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), FP; each frame uses the same order in lines.
REQ-024 hs_active SHALL be h_cnt<H_SYNC; vtc_hs_o SHALL equal HS_POL when active and ~HS_POL otherwise.
REQ-025 vs_active SHALL be v_cnt<V_SYNC, changing only at line start (h_cnt=0); vtc_vs_o SHALL equal VS_POL when active and ~VS_POL otherwise.
REQ-026 vtc_de_o SHALL be 1 only when h_cnt is in the ACTIVE region AND v_cnt is in the ACTIVE region.
REQ-027 vtc_x_o SHALL be h_cnt-(H_SYNC+H_BP) and vtc_y_o SHALL be v_cnt-(V_SYNC+V_BP) when de; both SHALL be 0 otherwise.
REQ-028 vtc_fs_o SHALL be high for exactly one clock, when (h_cnt,v_cnt)=(0,0).
REQ-029 Latency: all outputs SHALL be registered; output at edge n+1 reflects counter state at edge n, and all outputs SHALL be mutually aligned.
REQ-030 vtc_en_i low SHALL synchronously clear both counters and drive the outputs to idle: syncs inactive, de/fs 0, x/y 0.
REQ-031 After vtc_en_i rises, counting SHALL start from (0,0), and vtc_fs_o SHALL pulse one clock later.
REQ-032 vtc_en_i falling mid-line or mid-frame SHALL abort immediately; no partial-line completion.
REQ-033 Each frame SHALL contain exactly V_ACTIVE de runs of exactly H_ACTIVE clocks each.
REQ-034 The output contract: vs active-high rising edge marks frame start and each hs rising edge marks a line; this lets a downstream pattern stage count lines from hs edges and reset its line count on vs.

Reset
REQ-035 While vtc_rstn_i is low: h_cnt=v_cnt=0; vtc_hs_o=~HS_POL and vtc_vs_o=~VS_POL; vtc_de_o=vtc_fs_o=0; vtc_x_o=vtc_y_o=0.
REQ-036 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-037 After reset release with vtc_en_i high, behaviour SHALL match REQ-031.

Verification
REQ-038 Small params H=8/2/2/4 (ACTIVE/FP/SYNC/BP), V=4/1/1/2, en high -> H_TOTAL 16, V_TOTAL 8; hs high on h 0-1; de high on h 6-13 of lines 3-6; fs once per 128 clocks.
REQ-039 Same params, check x/y -> x runs 0..7 on each active line; y runs 0..3 across the frame; x/y are 0 outside de.
REQ-040 HS_POL=0, VS_POL=0 -> hs/vs are inverted relative to REQ-038; de and fs are unchanged.
REQ-041 vtc_en_i dropped at h=10, v=4 for 3 clocks, then raised -> outputs idle 1 clock later; restart at (0,0); fs pulses 1 clock after the rise.
REQ-042 vtc_rstn_i pulsed low between clock edges mid-active -> de=0 and x=0 immediately; normal frame after release.
REQ-043 Default 1080p params over 2 frames -> 1080x1920 de clocks per frame; frame period 2475000 clocks.
